// File: rtl/pipeline_ctrl_sequencer.sv
// pipeline_ctrl_sequencer
//   Control sequencer for the single-thread 5-stage core. Decodes the 6-bit
//   opcode at register fetch into a 20-bit control word and delays each
//   stage's fields through per-stage shift registers. It also owns the stage
//   freeze lines: staggered enable/disable ramps, bubble insertion on
//   read-after-write stalls and squashing of younger work on a taken branch.
//
// Ports
//   clock, reset            core clock; synchronous active-high reset
//   enable_in               run (1) / drain to frozen (0)
//   opcode_valid_in         opcode_in carries a new instruction
//   opcode_in[5:0]          instruction opcode
//   branch_taken_in         one-cycle pulse from the branch unit
//   raw_hazard_in           level from the hazard detector
//   ID fields               read_data_1/2, engage_reg, write_reg_mux,
//                           sign_extend_mux, alu_op[ALUOP_W-1:0]
//   EX fields               bu_op[2:0], alu_mux_1/2, alu_ignore_overflow
//   MEM fields              mem_read, mem_write
//   WB fields               write_back_mux, write_special_reg, write_back
//   stage_freeze_out[4:0]   IF,ID,EX,MEM,WB (bit 0 = IF); 1 = frozen
//   freeze_pc_out           holds the PC
//   illegal_opcode_out      one-cycle pulse on an undefined opcode
module pipeline_ctrl_sequencer #(
  parameter int EX_DELAY     = 1,
  parameter int MEM_DELAY    = 2,
  parameter int WB_DELAY     = 3,
  parameter int FLUSH_CYCLES = 2,
  parameter int ALUOP_W      = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable_in,
  input  logic               opcode_valid_in,
  input  logic [5:0]         opcode_in,
  input  logic               branch_taken_in,
  input  logic               raw_hazard_in,
  output logic               read_data_1_out,
  output logic               read_data_2_out,
  output logic               engage_reg_out,
  output logic               write_reg_mux_out,
  output logic               sign_extend_mux_out,
  output logic [ALUOP_W-1:0] alu_op_out,
  output logic [2:0]         bu_op_out,
  output logic               alu_mux_1_out,
  output logic               alu_mux_2_out,
  output logic               alu_ignore_overflow_out,
  output logic               mem_read_out,
  output logic               mem_write_out,
  output logic               write_back_mux_out,
  output logic               write_special_reg_out,
  output logic               write_back_out,
  output logic [4:0]         stage_freeze_out,
  output logic               freeze_pc_out,
  output logic               illegal_opcode_out
);

  localparam int MEM_D = MEM_DELAY - EX_DELAY;
  localparam int WB_D  = WB_DELAY - MEM_DELAY;
  localparam logic [2:0] FLUSH_LAST = 3'(FLUSH_CYCLES);

  localparam logic [4:0] FRZ_ALL   = 5'b11111;
  localparam logic [4:0] FRZ_FRONT = 5'b00011;

  typedef enum logic [2:0] {
    ST_OFF,
    ST_RAMP_UP,
    ST_RUN,
    ST_STALL,
    ST_FLUSH,
    ST_RAMP_DOWN
  } state_t;

  state_t      state;
  logic [2:0]  step;
  logic [2:0]  flush_cnt;

  logic [19:0] id_q;
  logic [10:0] ex_pipe  [EX_DELAY];
  logic [4:0]  mem_pipe [MEM_D];
  logic [2:0]  wb_pipe  [WB_D];

  logic        active;
  logic        branch_now;
  logic        stall_now;
  logic        sample;
  logic        squash;
  logic        dec_illegal;
  logic [19:0] dec_word;

  // Returns {illegal, control_word}.
  function automatic logic [20:0] decode(input logic [5:0] op);
    logic [20:0] r;
    r = '0;
    if (op[5:4] == 2'b01 && op[3:0] != 4'd0) begin
      r[19:0] = {5'b10101, op[3:0], 11'h0C6};
    end else begin
      case (op)
        6'b000000: r[19:0] = 20'hA88D2;
        6'b000001: r[19:0] = 20'h888C8;
        6'b000010: r[19:0] = 20'h10944;
        6'b000011: r[19:0] = 20'h58904;
        6'b000100: r[19:0] = 20'hD8C44;
        6'b000101: r[19:0] = 20'hD8D44;
        6'b000110: r[19:0] = 20'hD8E44;
        6'b000111: r[19:0] = 20'hD8F44;
        6'b001000: r[19:0] = 20'hF8084;
        6'b001001: r[19:0] = 20'hF8087;
        6'b010000: r[19:0] = 20'hF8086;
        6'b110000: r[19:0] = 20'hF80A6;
        default:   r[20]   = 1'b1;
      endcase
    end
    return r;
  endfunction

  // Freeze pattern after n ramp-up steps: IF+ID first, then EX, MEM, WB.
  function automatic logic [4:0] ramp_up_freeze(input logic [2:0] n);
    logic [4:0] f;
    case (n)
      3'd1:    f = 5'b11100;
      3'd2:    f = 5'b11000;
      3'd3:    f = 5'b10000;
      default: f = 5'b00000;
    endcase
    return f;
  endfunction

  // Stall and branch act on the edge that samples them, so the instruction
  // already in ID is held (or squashed) immediately rather than one cycle late.
  always_comb begin
    active     = (state == ST_RUN) || (state == ST_STALL);
    branch_now = active && enable_in && branch_taken_in;
    stall_now  = active && enable_in && !branch_taken_in && raw_hazard_in;
    sample     = opcode_valid_in && ((state == ST_RUN) || (state == ST_FLUSH));
    squash     = (state == ST_FLUSH) || branch_now;
    {dec_illegal, dec_word} = decode(opcode_in);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state            <= ST_OFF;
      step             <= '0;
      flush_cnt        <= '0;
      stage_freeze_out <= FRZ_ALL;
      freeze_pc_out    <= 1'b1;
    end else begin
      case (state)
        ST_OFF: begin
          if (enable_in) begin
            state            <= ST_RAMP_UP;
            step             <= 3'd1;
            stage_freeze_out <= ramp_up_freeze(3'd1);
            freeze_pc_out    <= 1'b0;
          end
        end
        ST_RAMP_UP: begin
          if (step == 3'd4) begin
            state <= ST_RUN;
            step  <= '0;
          end else begin
            step             <= step + 3'd1;
            stage_freeze_out <= ramp_up_freeze(step + 3'd1);
          end
        end
        ST_RUN, ST_STALL, ST_FLUSH: begin
          if (!enable_in) begin
            state            <= ST_RAMP_DOWN;
            step             <= 3'd1;
            stage_freeze_out <= ~ramp_up_freeze(3'd1);
            freeze_pc_out    <= 1'b1;
          end else if (branch_now) begin
            state            <= ST_FLUSH;
            flush_cnt        <= 3'd1;
            stage_freeze_out <= '0;
            freeze_pc_out    <= 1'b0;
          end else if (state == ST_FLUSH) begin
            if (flush_cnt == FLUSH_LAST) state <= ST_RUN;
            else flush_cnt <= flush_cnt + 3'd1;
            stage_freeze_out <= '0;
            freeze_pc_out    <= 1'b0;
          end else if (raw_hazard_in) begin
            state            <= ST_STALL;
            stage_freeze_out <= FRZ_FRONT;
            freeze_pc_out    <= 1'b1;
          end else begin
            state            <= ST_RUN;
            stage_freeze_out <= '0;
            freeze_pc_out    <= 1'b0;
          end
        end
        ST_RAMP_DOWN: begin
          if (step == 3'd4) begin
            state <= ST_OFF;
            step  <= '0;
          end else begin
            step             <= step + 3'd1;
            stage_freeze_out <= ~ramp_up_freeze(step + 3'd1);
          end
        end
        default: begin
          state            <= ST_OFF;
          stage_freeze_out <= FRZ_ALL;
          freeze_pc_out    <= 1'b1;
        end
      endcase
    end
  end

  // Control-word datapath: the ID register and the EX/MEM/WB delay pipes.
  // The pipes shift every cycle; only the ID register is ever held.
  always_ff @(posedge clock) begin
    if (reset) begin
      id_q               <= '0;
      illegal_opcode_out <= 1'b0;
      for (int unsigned i = 0; i < EX_DELAY; i++) ex_pipe[i]  <= '0;
      for (int unsigned i = 0; i < MEM_D; i++)    mem_pipe[i] <= '0;
      for (int unsigned i = 0; i < WB_D; i++)     wb_pipe[i]  <= '0;
    end else begin
      illegal_opcode_out <= sample && !squash && !stall_now && dec_illegal;

      if (stall_now) begin
        ex_pipe[0] <= '0;
        for (int unsigned i = 1; i < EX_DELAY; i++) ex_pipe[i] <= ex_pipe[i-1];
      end else begin
        id_q <= (sample && !squash) ? dec_word : '0;
        if (branch_now) begin
          for (int unsigned i = 0; i < EX_DELAY; i++) ex_pipe[i] <= '0;
        end else begin
          ex_pipe[0] <= id_q[10:0];
          for (int unsigned i = 1; i < EX_DELAY; i++) ex_pipe[i] <= ex_pipe[i-1];
        end
      end

      mem_pipe[0] <= ex_pipe[EX_DELAY-1][4:0];
      for (int unsigned i = 1; i < MEM_D; i++) mem_pipe[i] <= mem_pipe[i-1];
      wb_pipe[0] <= mem_pipe[MEM_D-1][2:0];
      for (int unsigned i = 1; i < WB_D; i++) wb_pipe[i] <= wb_pipe[i-1];
    end
  end

  assign read_data_1_out         = id_q[19];
  assign read_data_2_out         = id_q[18];
  assign engage_reg_out          = id_q[17];
  assign write_reg_mux_out       = id_q[16];
  assign sign_extend_mux_out     = id_q[15];
  assign alu_op_out              = ALUOP_W'(id_q[14:11]);
  assign bu_op_out               = ex_pipe[EX_DELAY-1][10:8];
  assign alu_mux_1_out           = ex_pipe[EX_DELAY-1][7];
  assign alu_mux_2_out           = ex_pipe[EX_DELAY-1][6];
  assign alu_ignore_overflow_out = ex_pipe[EX_DELAY-1][5];
  assign mem_read_out            = mem_pipe[MEM_D-1][4];
  assign mem_write_out           = mem_pipe[MEM_D-1][3];
  assign write_back_mux_out      = wb_pipe[WB_D-1][2];
  assign write_special_reg_out   = wb_pipe[WB_D-1][1];
  assign write_back_out          = wb_pipe[WB_D-1][0];

endmodule

// File: tb/tb_pipeline_ctrl_sequencer.sv
// Self-checking bench for pipeline_ctrl_sequencer: directed scenarios followed
// by randomized traffic, all compared against a queue-based reference model.
module tb_pipeline_ctrl_sequencer;

  localparam int EX_D  = 1;
  localparam int MEM_D = 2;
  localparam int WB_D  = 3;
  localparam int FLUSH = 2;
  localparam int AW    = 4;

  logic          clock;
  logic          reset;
  logic          enable_in;
  logic          opcode_valid_in;
  logic [5:0]    opcode_in;
  logic          branch_taken_in;
  logic          raw_hazard_in;
  logic          read_data_1_out, read_data_2_out, engage_reg_out;
  logic          write_reg_mux_out, sign_extend_mux_out;
  logic [AW-1:0] alu_op_out;
  logic [2:0]    bu_op_out;
  logic          alu_mux_1_out, alu_mux_2_out, alu_ignore_overflow_out;
  logic          mem_read_out, mem_write_out;
  logic          write_back_mux_out, write_special_reg_out, write_back_out;
  logic [4:0]    stage_freeze_out;
  logic          freeze_pc_out;
  logic          illegal_opcode_out;

  pipeline_ctrl_sequencer #(
    .EX_DELAY(EX_D), .MEM_DELAY(MEM_D), .WB_DELAY(WB_D),
    .FLUSH_CYCLES(FLUSH), .ALUOP_W(AW)
  ) dut (
    .clock(clock), .reset(reset), .enable_in(enable_in),
    .opcode_valid_in(opcode_valid_in), .opcode_in(opcode_in),
    .branch_taken_in(branch_taken_in), .raw_hazard_in(raw_hazard_in),
    .read_data_1_out(read_data_1_out), .read_data_2_out(read_data_2_out),
    .engage_reg_out(engage_reg_out), .write_reg_mux_out(write_reg_mux_out),
    .sign_extend_mux_out(sign_extend_mux_out), .alu_op_out(alu_op_out),
    .bu_op_out(bu_op_out), .alu_mux_1_out(alu_mux_1_out),
    .alu_mux_2_out(alu_mux_2_out),
    .alu_ignore_overflow_out(alu_ignore_overflow_out),
    .mem_read_out(mem_read_out), .mem_write_out(mem_write_out),
    .write_back_mux_out(write_back_mux_out),
    .write_special_reg_out(write_special_reg_out),
    .write_back_out(write_back_out), .stage_freeze_out(stage_freeze_out),
    .freeze_pc_out(freeze_pc_out), .illegal_opcode_out(illegal_opcode_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef enum int {M_OFF, M_UP, M_RUN, M_STALL, M_FLUSH, M_DOWN} mode_t;
  mode_t       m_mode;
  int          m_step;
  int          m_cnt;
  logic        m_ill;
  // m_q[k] = control word of the instruction k cycles past its ID register.
  logic [19:0] m_q [$];

  task automatic decode_ref(input logic [5:0] op, output logic [19:0] w, output logic ill);
    int v;
    v = int'(op);
    ill = 1'b0;
    w = 20'h0;
    if (v >= 17 && v <= 31)  w = 20'hA80C6 | (20'(op[3:0]) << 11);
    else if (v == 0)         w = 20'hA88D2;
    else if (v == 1)         w = 20'h888C8;
    else if (v == 2)         w = 20'h10944;
    else if (v == 3)         w = 20'h58904;
    else if (v >= 4 && v <= 7) w = 20'hD8C44 + (20'(v - 4) << 8);
    else if (v == 8)         w = 20'hF8084;
    else if (v == 9)         w = 20'hF8087;
    else if (v == 16)        w = 20'hF8086;
    else if (v == 48)        w = 20'hF80A6;
    else                     ill = 1'b1;
  endtask

  // Bits already frozen after n ramp-down steps: 2 for the first, then +1.
  function automatic logic [4:0] down_mask(input int n);
    int m;
    m = (1 << (n + 1)) - 1;
    return m[4:0];
  endfunction

  function automatic logic [4:0] exp_freeze();
    case (m_mode)
      M_OFF:   return 5'b11111;
      M_UP:    return ~down_mask(m_step);
      M_DOWN:  return down_mask(m_step);
      M_STALL: return 5'b00011;
      default: return 5'b00000;
    endcase
  endfunction

  task automatic model_reset();
    m_mode = M_OFF; m_step = 0; m_cnt = 0; m_ill = 1'b0;
    m_q.delete();
    for (int k = 0; k <= WB_D; k++) m_q.push_back(20'h0);
  endtask

  task automatic model_update();
    logic [19:0] w;
    logic ill, act, brk, stl, smp, sq;
    if (reset) begin
      model_reset();
      return;
    end
    act = (m_mode == M_RUN) || (m_mode == M_STALL);
    brk = act && enable_in && branch_taken_in;
    stl = act && enable_in && !branch_taken_in && raw_hazard_in;
    smp = opcode_valid_in && (m_mode == M_RUN || m_mode == M_FLUSH) && !stl;
    sq  = (m_mode == M_FLUSH) || brk;
    decode_ref(opcode_in, w, ill);
    m_ill = smp && !sq && ill;
    void'(m_q.pop_back());
    if (stl) m_q.insert(1, 20'h0);
    else begin
      m_q.push_front((smp && !sq) ? w : 20'h0);
      if (brk) for (int k = 0; k <= EX_D; k++) m_q[k] = 20'h0;
    end
    case (m_mode)
      M_OFF: if (enable_in) begin m_mode = M_UP; m_step = 1; end
      M_UP: if (m_step == 4) m_mode = M_RUN; else m_step++;
      M_DOWN: if (m_step == 4) m_mode = M_OFF; else m_step++;
      default: begin
        if (!enable_in) begin m_mode = M_DOWN; m_step = 1; end
        else if (brk) begin m_mode = M_FLUSH; m_cnt = 1; end
        else if (m_mode == M_FLUSH) begin
          if (m_cnt == FLUSH) m_mode = M_RUN; else m_cnt++;
        end
        else m_mode = raw_hazard_in ? M_STALL : M_RUN;
      end
    endcase
  endtask

  task automatic compare_all();
    logic [19:0] qid, qex, qmem, qwb;
    qid = m_q[0]; qex = m_q[EX_D]; qmem = m_q[MEM_D]; qwb = m_q[WB_D];
    check("id_fields", 32'({read_data_1_out, read_data_2_out, engage_reg_out,
          write_reg_mux_out, sign_extend_mux_out, alu_op_out}), 32'(qid[19:11]));
    check("ex_fields", 32'({bu_op_out, alu_mux_1_out, alu_mux_2_out,
          alu_ignore_overflow_out}), 32'(qex[10:5]));
    check("mem_fields", 32'({mem_read_out, mem_write_out}), 32'(qmem[4:3]));
    check("wb_fields", 32'({write_back_mux_out, write_special_reg_out,
          write_back_out}), 32'(qwb[2:0]));
    check("stage_freeze", 32'(stage_freeze_out), 32'(exp_freeze()));
    check("freeze_pc", 32'(freeze_pc_out), 32'(exp_freeze() & 5'b1));
    check("illegal", 32'(illegal_opcode_out), 32'(m_ill));
  endtask

  task automatic step_cycle();
    @(posedge clock);
    model_update();
    #1;
    compare_all();
  endtask

  task automatic drive(input logic en, input logic ov, input logic [5:0] op,
                       input logic br, input logic hz);
    enable_in = en; opcode_valid_in = ov; opcode_in = op;
    branch_taken_in = br; raw_hazard_in = hz;
  endtask

  logic [4:0] ramp_tbl [0:4];
  logic [5:0] rop;

  initial begin
    ramp_tbl = '{5'b11111, 5'b11100, 5'b11000, 5'b10000, 5'b00000};
    model_reset();
    reset = 1'b1;
    drive(0, 0, 6'd0, 0, 0);
    #1;
    step_cycle();
    step_cycle();
    check("reset_freeze", 32'(stage_freeze_out), 32'(ramp_tbl[0]));
    check("reset_pc", 32'(freeze_pc_out), 32'd1);
    reset = 1'b0;
    step_cycle();

    // ramp-up
    drive(1, 0, 6'd0, 0, 0);
    for (int i = 1; i <= 4; i++) begin
      step_cycle();
      check("ramp_up", 32'(stage_freeze_out), 32'(ramp_tbl[i]));
    end
    step_cycle();

    // lw latency
    drive(1, 1, 6'b000000, 0, 0);
    step_cycle();
    check("lw_id_aluop", 32'(alu_op_out), 32'd1);
    check("lw_id_engage", 32'(engage_reg_out), 32'd1);
    drive(1, 0, 6'd0, 0, 0);
    step_cycle();
    check("lw_ex_mux", 32'({alu_mux_1_out, alu_mux_2_out}), 32'd3);
    step_cycle();
    check("lw_mem_read", 32'(mem_read_out), 32'd1);
    step_cycle();
    check("lw_wb", 32'({write_back_mux_out, write_special_reg_out, write_back_out}), 32'b010);

    // immediate sweep and illegal opcode
    for (int i = 17; i <= 31; i++) begin
      drive(1, 1, 6'(i), 0, 0);
      step_cycle();
    end
    check("srai_aluop", 32'(alu_op_out), 32'hF);
    drive(1, 1, 6'b111111, 0, 0);
    step_cycle();
    check("illegal_pulse", 32'(illegal_opcode_out), 32'd1);
    drive(1, 0, 6'd0, 0, 0);
    step_cycle();
    check("illegal_once", 32'(illegal_opcode_out), 32'd0);

    // addi with a two-cycle hazard behind it
    drive(1, 1, 6'b010001, 0, 0);
    step_cycle();
    drive(1, 0, 6'd0, 0, 1);
    step_cycle();
    check("stall_pc1", 32'(freeze_pc_out), 32'd1);
    check("stall_ex_zero1", 32'(alu_mux_1_out), 32'd0);
    step_cycle();
    check("stall_pc2", 32'(freeze_pc_out), 32'd1);
    check("stall_ex_zero2", 32'(alu_mux_1_out), 32'd0);
    drive(1, 0, 6'd0, 0, 0);
    step_cycle();
    check("addi_ex_late", 32'({alu_mux_1_out, alu_mux_2_out}), 32'd3);
    check("stall_release", 32'(freeze_pc_out), 32'd0);

    // beq then taken branch; following lw's are squashed
    drive(1, 1, 6'b000100, 0, 0);
    step_cycle();
    drive(1, 0, 6'd0, 0, 0);
    step_cycle();
    drive(1, 1, 6'b000000, 1, 0);
    step_cycle();
    drive(1, 1, 6'b000000, 0, 0);
    for (int i = 0; i < 6; i++) begin
      step_cycle();
      if (i < 2) check("flush_id_zero", 32'(engage_reg_out), 32'd0);
    end

    // branch + hazard together, then reset mid-flush
    drive(1, 0, 6'd0, 1, 1);
    step_cycle();
    check("br_hz_flush", 32'(freeze_pc_out), 32'd0);
    drive(1, 1, 6'b000001, 0, 1);
    step_cycle();
    reset = 1'b1;
    step_cycle();
    check("rst_mid_freeze", 32'(stage_freeze_out), 32'h1F);
    check("rst_mid_pc", 32'(freeze_pc_out), 32'd1);
    reset = 1'b0;

    // randomized traffic
    drive(1, 0, 6'd0, 0, 0);
    for (int c = 0; c < 4000; c++) begin
      reset = ($urandom_range(0, 499) == 0);
      if (enable_in) begin
        if ($urandom_range(0, 59) == 0) enable_in = 1'b0;
      end else if ($urandom_range(0, 7) == 0) enable_in = 1'b1;
      if ($urandom_range(0, 5) == 0) raw_hazard_in = ~raw_hazard_in;
      branch_taken_in = ($urandom_range(0, 11) == 0);
      opcode_valid_in = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 9))
        0: rop = 6'd0;
        1: rop = 6'd1;
        2: rop = 6'($urandom_range(4, 7));
        3: rop = 6'($urandom_range(2, 3));
        4: rop = 6'($urandom_range(8, 9));
        5: rop = ($urandom_range(0, 1) == 0) ? 6'd16 : 6'd48;
        6, 7: rop = 6'($urandom_range(17, 31));
        default: rop = 6'($urandom_range(0, 63));
      endcase
      opcode_in = rop;
      step_cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
